// File: rtl/slot_io_pkg.sv
// Shared constants and control-state encoding for the slot input conditioner.
package slot_io_pkg;

    localparam int SLOT_PINS       = 22;
    localparam int FILT_W_DEFAULT  = 8;
    localparam int SYNC_STAGES_MIN = 2;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/slot_pin_filter.sv
// One pad input: synchroniser chain, consecutive-cycle glitch filter and
// registered edge pulses qualified by the per-pin enables and output-enable mask.
module slot_pin_filter
    import slot_io_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_MIN,
    parameter int FILT_W      = FILT_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pin_i,
    input  logic              outen_i,
    input  logic              rise_en_i,
    input  logic              fall_en_i,
    input  logic [FILT_W-1:0] filter_len_i,
    input  logic              prime_i,
    input  logic              run_i,
    output logic              state_o,
    output logic              rise_o,
    output logic              fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [FILT_W-1:0]      cnt_q, cnt_d;
    logic                   state_q, state_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (prime_i) begin
            // Adopt the settled level silently so a pin high out of reset makes no edge.
            state_d = sync_s;
            cnt_d   = '0;
        end else if (run_i) begin
            if (sync_s == state_q) begin
                cnt_d = '0;
            end else if (cnt_q >= filter_len_i) begin
                state_d = sync_s;
                cnt_d   = '0;
                rise_d  = sync_s & rise_en_i & ~outen_i;
                fall_d  = ~sync_s & fall_en_i & ~outen_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign state_o = state_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/slot_input_conditioner.sv
// Per-slot input conditioner: priming FSM, per-pin filters, sticky W1C event
// flags and a registered interrupt.
module slot_input_conditioner
    import slot_io_pkg::*;
#(
    parameter int N_PINS      = SLOT_PINS,
    parameter int SYNC_STAGES = SYNC_STAGES_MIN,
    parameter int FILT_W      = FILT_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_PINS-1:0] pin_in_i,
    input  logic [N_PINS-1:0] pin_outen_i,
    input  logic [FILT_W-1:0] filter_len_i,
    input  logic [N_PINS-1:0] rise_en_i,
    input  logic [N_PINS-1:0] fall_en_i,
    input  logic [N_PINS-1:0] clear_flags_i,
    output logic [N_PINS-1:0] pin_state_o,
    output logic [N_PINS-1:0] rise_pulse_o,
    output logic [N_PINS-1:0] fall_pulse_o,
    output logic [N_PINS-1:0] event_flags_o,
    output logic              irq_o,
    output logic              ready_o,
    output ctrl_state_e       state_o
);

    localparam int INIT_CW = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;

    ctrl_state_e          state_q, state_d;
    logic [INIT_CW-1:0]   init_cnt_q, init_cnt_d;
    logic [N_PINS-1:0]    flags_q, flags_d;
    logic                 irq_q;
    logic                 prime_s;
    logic                 run_s;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_CW'(SYNC_STAGES - 1)) begin
                    state_d    = ST_PRIME;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_PRIME: state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign prime_s = (state_q == ST_PRIME);
    assign run_s   = (state_q == ST_RUN);

    for (genvar i = 0; i < N_PINS; i++) begin : g_pin
        slot_pin_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W)
        ) u_filter (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .pin_i        (pin_in_i[i]),
            .outen_i      (pin_outen_i[i]),
            .rise_en_i    (rise_en_i[i]),
            .fall_en_i    (fall_en_i[i]),
            .filter_len_i (filter_len_i),
            .prime_i      (prime_s),
            .run_i        (run_s),
            .state_o      (pin_state_o[i]),
            .rise_o       (rise_pulse_o[i]),
            .fall_o       (fall_pulse_o[i])
        );
    end

    // A new edge in the same cycle as its clear strobe keeps the flag set.
    assign flags_d = (flags_q & ~clear_flags_i) | rise_pulse_o | fall_pulse_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            irq_q   <= |flags_q;
        end
    end

    assign event_flags_o = flags_q;
    assign irq_o         = irq_q;
    assign ready_o       = run_s;
    assign state_o       = state_q;

endmodule

// File: tb/tb_slot_input_conditioner.sv
// Bench for slot_input_conditioner: directed scenarios plus a randomized run
// against a behavioural model of the filter, edge and flag rules.
module tb_slot_input_conditioner;
    import slot_io_pkg::*;

    localparam int NP = 22;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] pin_in, pin_outen, rise_en, fall_en, clear_flags;
    logic [FW-1:0] filter_len;
    logic [NP-1:0] pin_state, rise_pulse, fall_pulse, event_flags;
    logic          irq, ready;
    ctrl_state_e   dbg_state;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [NP-1:0] m_level, m_rise, m_fall, m_flags;
    logic          m_irq;
    int            m_k;
    int            mrun [NP];
    logic [NP-1:0] pad_q [$];

    always #5 clk = ~clk;

    slot_input_conditioner dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pin_in_i      (pin_in),
        .pin_outen_i   (pin_outen),
        .filter_len_i  (filter_len),
        .rise_en_i     (rise_en),
        .fall_en_i     (fall_en),
        .clear_flags_i (clear_flags),
        .pin_state_o   (pin_state),
        .rise_pulse_o  (rise_pulse),
        .fall_pulse_o  (fall_pulse),
        .event_flags_o (event_flags),
        .irq_o         (irq),
        .ready_o       (ready),
        .state_o       (dbg_state)
    );

    // Model: sync sees the pad two edges late; a level is accepted after
    // filter_len+1 consecutive mismatched samples in RUN (edges >= 4 after release).
    task automatic model_update();
        logic [NP-1:0] sync_v;
        if (rst) begin
            m_level = '0; m_rise = '0; m_fall = '0; m_flags = '0; m_irq = 1'b0;
            m_k = 0;
            pad_q.delete();
            for (int i = 0; i < NP; i++) mrun[i] = 0;
        end else begin
            sync_v  = (pad_q.size() >= 2) ? pad_q[pad_q.size()-2] : '0;
            m_irq   = |m_flags;
            m_flags = (m_flags & ~clear_flags) | m_rise | m_fall;
            m_rise  = '0;
            m_fall  = '0;
            if (m_k < 100000) m_k++;
            if (m_k == 3) begin
                m_level = sync_v;
                for (int i = 0; i < NP; i++) mrun[i] = 0;
            end else if (m_k >= 4) begin
                for (int i = 0; i < NP; i++) begin
                    if (sync_v[i] != m_level[i]) mrun[i]++;
                    else mrun[i] = 0;
                    if (mrun[i] >= int'(filter_len) + 1) begin
                        m_level[i] = sync_v[i];
                        mrun[i]    = 0;
                        m_rise[i]  = sync_v[i] & rise_en[i] & ~pin_outen[i];
                        m_fall[i]  = ~sync_v[i] & fall_en[i] & ~pin_outen[i];
                    end
                end
            end
            pad_q.push_back(pin_in);
            if (pad_q.size() > 2) void'(pad_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pin_in = 22'h000005; pin_outen = '0; filter_len = 8'd3;
        rise_en = '1; fall_en = '0; clear_flags = '0;
        repeat (3) tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (dbg_state !== ST_INIT) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_INIT); end
        checks++; if ({pin_state, event_flags, irq} !== '0) begin errors++; $display("FAIL reset_outputs got=%h/%h/%b exp=0", pin_state, event_flags, irq); end
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++; if (ready !== (c == 3)) begin errors++; $display("FAIL prime_ready cycle=%0d got=%b exp=%b", c, ready, c == 3); end
        end
        checks++; if (pin_state !== 22'h000005) begin errors++; $display("FAIL prime_pin_state got=%h exp=000005", pin_state); end
        repeat (3) tick();
        checks++; if ({rise_pulse, fall_pulse, event_flags} !== '0) begin errors++; $display("FAIL prime_no_events got=%h/%h/%h exp=0", rise_pulse, fall_pulse, event_flags); end
        pin_in = '0;
        repeat (8) tick();
        checks++; if ({pin_state, event_flags} !== '0) begin errors++; $display("FAIL drop_quiet got=%h/%h exp=0", pin_state, event_flags); end
    endtask

    task automatic test_rise();
        pin_in[0] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++; if ({pin_state[0], rise_pulse[0]} !== 2'b00) begin errors++; $display("FAIL rise_early cycle=%0d got=%b%b exp=00", c, pin_state[0], rise_pulse[0]); end
        end
        tick();
        checks++; if (pin_state[0] !== 1'b1) begin errors++; $display("FAIL rise_state got=%b exp=1", pin_state[0]); end
        checks++; if (rise_pulse !== 22'h000001) begin errors++; $display("FAIL rise_pulse got=%h exp=000001", rise_pulse); end
        tick();
        checks++; if (rise_pulse !== '0) begin errors++; $display("FAIL rise_single got=%h exp=0", rise_pulse); end
        checks++; if (event_flags !== 22'h000001 || irq !== 1'b0) begin errors++; $display("FAIL rise_flag got=%h irq=%b exp=000001 irq=0", event_flags, irq); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq got=%b exp=1", irq); end
    endtask

    task automatic test_glitch();
        for (int c = 0; c < 13; c++) begin
            pin_in[1] = (c < 3);
            tick();
            checks++; if ({pin_state[1], rise_pulse[1]} !== 2'b00) begin errors++; $display("FAIL glitch cycle=%0d got=%b%b exp=00", c, pin_state[1], rise_pulse[1]); end
        end
        checks++; if (event_flags[1] !== 1'b0) begin errors++; $display("FAIL glitch_flag got=%b exp=0", event_flags[1]); end
    endtask

    task automatic test_outen();
        logic saw;
        saw = 1'b0;
        fall_en = '1; pin_outen[2] = 1'b1; pin_in[2] = 1'b1;
        repeat (8) begin tick(); saw |= rise_pulse[2] | fall_pulse[2]; end
        checks++; if (pin_state[2] !== 1'b1) begin errors++; $display("FAIL outen_high got=%b exp=1", pin_state[2]); end
        pin_in[2] = 1'b0;
        repeat (8) begin tick(); saw |= rise_pulse[2] | fall_pulse[2]; end
        checks++; if (pin_state[2] !== 1'b0) begin errors++; $display("FAIL outen_low got=%b exp=0", pin_state[2]); end
        checks++; if ({saw, event_flags[2]} !== 2'b00) begin errors++; $display("FAIL outen_masked got=%b%b exp=00", saw, event_flags[2]); end
        pin_outen = '0; fall_en = '0;
    endtask

    task automatic test_clear_collision();
        pin_in[0] = 1'b0;
        repeat (8) tick();
        checks++; if ({pin_state[0], event_flags[0]} !== 2'b01) begin errors++; $display("FAIL clr_setup got=%b%b exp=01", pin_state[0], event_flags[0]); end
        pin_in[0] = 1'b1;
        repeat (6) tick();
        checks++; if (rise_pulse[0] !== 1'b1) begin errors++; $display("FAIL clr_pulse got=%b exp=1", rise_pulse[0]); end
        clear_flags[0] = 1'b1;
        tick();
        clear_flags = '0;
        checks++; if (event_flags[0] !== 1'b1) begin errors++; $display("FAIL clr_set_wins got=%b exp=1", event_flags[0]); end
        tick();
        checks++; if (event_flags[0] !== 1'b1) begin errors++; $display("FAIL clr_hold got=%b exp=1", event_flags[0]); end
        clear_flags[0] = 1'b1;
        tick();
        clear_flags = '0;
        checks++; if (event_flags !== '0 || irq !== 1'b1) begin errors++; $display("FAIL clr_lone got=%h irq=%b exp=0 irq=1", event_flags, irq); end
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_irq_drop got=%b exp=0", irq); end
    endtask

    task automatic test_fast_filter();
        logic saw;
        filter_len = 8'd0; rise_en[3] = 1'b0; fall_en[3] = 1'b1;
        pin_in[3] = 1'b1;
        repeat (3) tick();
        checks++; if ({pin_state[3], rise_pulse[3]} !== 2'b10) begin errors++; $display("FAIL fast_up got=%b%b exp=10", pin_state[3], rise_pulse[3]); end
        repeat (2) tick();
        checks++; if (event_flags !== '0) begin errors++; $display("FAIL fast_noflag got=%h exp=0", event_flags); end
        pin_in[3] = 1'b0;
        repeat (2) tick();
        checks++; if (pin_state[3] !== 1'b1) begin errors++; $display("FAIL fast_fall_early got=%b exp=1", pin_state[3]); end
        tick();
        checks++; if (pin_state[3] !== 1'b0 || fall_pulse !== 22'h000008) begin errors++; $display("FAIL fast_fall got=%b/%h exp=0/000008", pin_state[3], fall_pulse); end
        tick();
        checks++; if (fall_pulse !== '0 || event_flags !== 22'h000008) begin errors++; $display("FAIL fast_fall_flag got=%h/%h exp=0/000008", fall_pulse, event_flags); end
        pin_in[3] = 1'b1; saw = 1'b0;
        repeat (3) begin tick(); saw |= rise_pulse[3]; end
        checks++; if ({pin_state[3], saw} !== 2'b10) begin errors++; $display("FAIL fast_rise_silent got=%b%b exp=10", pin_state[3], saw); end
        filter_len = 8'd5; pin_in[3] = 1'b0;
        repeat (4) tick();
        checks++; if (pin_state[3] !== 1'b1) begin errors++; $display("FAIL midcount got=%b exp=1", pin_state[3]); end
        rst = 1'b1;
        tick();
        checks++; if ({pin_state, rise_pulse, fall_pulse, event_flags, irq, ready} !== '0) begin
            errors++; $display("FAIL rst_midcount got=%h/%h/%h/%h/%b/%b exp=0", pin_state, rise_pulse, fall_pulse, event_flags, irq, ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        rst = 1'b1; pin_in = NP'($urandom); clear_flags = '0;
        rise_en = NP'($urandom); fall_en = NP'($urandom); pin_outen = NP'($urandom);
        filter_len = FW'($urandom_range(0, 4));
        repeat (2) tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 100 == 50) filter_len = FW'($urandom_range(0, 4));
            if (cyc % 150 == 0) begin
                rise_en = NP'($urandom); fall_en = NP'($urandom);
                pin_outen = NP'($urandom) & NP'($urandom);
            end
            for (int i = 0; i < NP; i++)
                if ($urandom_range(0, 3) == 0) pin_in[i] = ~pin_in[i];
            clear_flags = ($urandom_range(0, 7) == 0) ? NP'($urandom) : '0;
            rst = (cyc == 300 || cyc == 301);
            tick();
            checks++; if (pin_state !== m_level) begin errors++; $display("FAIL rnd_state cyc=%0d got=%h exp=%h", cyc, pin_state, m_level); end
            checks++; if (rise_pulse !== m_rise) begin errors++; $display("FAIL rnd_rise cyc=%0d got=%h exp=%h", cyc, rise_pulse, m_rise); end
            checks++; if (fall_pulse !== m_fall) begin errors++; $display("FAIL rnd_fall cyc=%0d got=%h exp=%h", cyc, fall_pulse, m_fall); end
            checks++; if (event_flags !== m_flags) begin errors++; $display("FAIL rnd_flags cyc=%0d got=%h exp=%h", cyc, event_flags, m_flags); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", cyc, irq, m_irq); end
            checks++; if (ready !== (m_k >= 3)) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, ready, m_k >= 3); end
        end
        rst = 1'b0; clear_flags = '0;
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_outen();
        test_clear_collision();
        test_fast_filter();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
